// File: rtl/pin_delay_pkg.sv
// Shared definitions for the AND-tree pin-delay sequencer.
// Holds the FSM state encoding, default settle/dwell timing, and the
// 8-step toggle table (drive vector, expected q, pin under test).
package pin_delay_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT   = 3'd1,
      APPLY  = 3'd2,
      SETTLE = 3'd3,
      HOLD   = 3'd4,
      FIN    = 3'd5
   } state_t;

   localparam int NUM_STEPS    = 8;
   localparam int DEF_SETTLE_A = 10;
   localparam int DEF_SETTLE_B = 12;
   localparam int DEF_SETTLE_C = 18;
   localparam int DEF_SETTLE_D = 22;
   localparam int DEF_DWELL    = 25;

   // Pin indices are bit positions in the abcd drive bus.
   localparam logic [1:0] PIN_D = 2'd0;
   localparam logic [1:0] PIN_C = 2'd1;
   localparam logic [1:0] PIN_B = 2'd2;
   localparam logic [1:0] PIN_A = 2'd3;

   // Drive vector per step: even steps drop one pin, odd steps restore 1111.
   function automatic logic [3:0] step_vec(input logic [2:0] s);
      logic [3:0] v;
      case (s)
         3'd0:    v = 4'b1110;
         3'd1:    v = 4'b1111;
         3'd2:    v = 4'b1101;
         3'd3:    v = 4'b1111;
         3'd4:    v = 4'b1011;
         3'd5:    v = 4'b1111;
         3'd6:    v = 4'b0111;
         default: v = 4'b1111;
      endcase
      return v;
   endfunction

   // The AND tree outputs 0 on a drop step and 1 on a restore step.
   function automatic logic step_exp(input logic [2:0] s);
      return s[0];
   endfunction

   // Pairs of steps test d, c, b, a in that order, which is abcd bit 0..3.
   function automatic logic [1:0] step_pin(input logic [2:0] s);
      return s[2:1];
   endfunction

endpackage

// File: rtl/pin_delay_timer.sv
// Saturating cycle counter with settle and dwell threshold compares.
// Latency: hits are combinational on the registered count; clr/en act on the next edge.
// No backpressure: the FSM owns clr/en; the count parks at all-ones instead of wrapping.
// Ports: clk/rst (sync active-high), clr (zero count), en (advance count),
//        settle_tgt/dwell_tgt (thresholds), settle_hit/dwell_hit (count >= threshold).
module pin_delay_timer #(
   parameter int CW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [CW-1:0] settle_tgt,
   input  logic [CW-1:0] dwell_tgt,
   output logic          settle_hit,
   output logic          dwell_hit
);

   localparam logic [CW-1:0] CNT_MAX = '1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != CNT_MAX)) begin
         cnt <= cnt + CW'(1);
      end
   end

   // >= rather than == so a threshold beyond reach of a short state still
   // releases on the next edge instead of being skipped over.
   assign settle_hit = (cnt >= settle_tgt);
   assign dwell_hit  = (cnt >= dwell_tgt);

endmodule

// File: rtl/pin_delay_sequencer.sv
// Sequences a 4-input AND-tree delay cell through a per-pin low/high toggle test.
// Latency: 224 cycles start->done at defaults; all outputs registered.
// No backpressure: start is a one-cycle request, ignored while busy.
// Ports: clk, rst (sync active-high), start, q_in (cell output) ->
//        abcd (cell drive, [3]=a..[0]=d), busy, sample (compare pulse),
//        done (end pulse), pass, init_fail, fail_mask (per-pin sticky mismatch).
module pin_delay_sequencer
   import pin_delay_pkg::*;
#(
   parameter int SETTLE_A = DEF_SETTLE_A,
   parameter int SETTLE_B = DEF_SETTLE_B,
   parameter int SETTLE_C = DEF_SETTLE_C,
   parameter int SETTLE_D = DEF_SETTLE_D,
   parameter int DWELL    = DEF_DWELL,
   parameter int CW       = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       q_in,
   output logic [3:0] abcd,
   output logic       busy,
   output logic       sample,
   output logic       done,
   output logic       pass,
   output logic       init_fail,
   output logic [3:0] fail_mask
);

   // The counter is cleared on the edge a vector is applied, so the edge
   // DWELL cycles later is reached when the count shows DWELL-1.
   localparam logic [CW-1:0] DWELL_TGT = (DWELL > 0) ? CW'(DWELL - 1) : '0;

   state_t        state, state_nxt;
   logic [2:0]    step, step_nxt;
   logic [3:0]    abcd_nxt;
   logic          busy_nxt;
   logic          sample_nxt;
   logic          done_nxt;
   logic          pass_nxt;
   logic          init_fail_nxt;
   logic [3:0]    fail_mask_nxt;

   logic          tmr_clr;
   logic          tmr_en;
   logic          settle_hit;
   logic          dwell_hit;
   logic [CW-1:0] pin_settle;
   logic [CW-1:0] settle_tgt;

   pin_delay_timer #(
      .CW (CW)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .clr        (tmr_clr),
      .en         (tmr_en),
      .settle_tgt (settle_tgt),
      .dwell_tgt  (DWELL_TGT),
      .settle_hit (settle_hit),
      .dwell_hit  (dwell_hit)
   );

   always_comb begin
      case (step_pin(step))
         PIN_D:   pin_settle = CW'(SETTLE_D);
         PIN_C:   pin_settle = CW'(SETTLE_C);
         PIN_B:   pin_settle = CW'(SETTLE_B);
         default: pin_settle = CW'(SETTLE_A);
      endcase
   end

   // INIT counts from the start edge and holds one extra cycle for the
   // start capture, so its compare lands at count SETTLE_D. Steps count
   // from the apply edge, so their compare lands at count settle-1.
   always_comb begin
      if (state == INIT) begin
         settle_tgt = CW'(SETTLE_D);
      end else if (pin_settle == '0) begin
         settle_tgt = '0;
      end else begin
         settle_tgt = pin_settle - CW'(1);
      end
   end

   always_comb begin
      state_nxt     = state;
      step_nxt      = step;
      abcd_nxt      = abcd;
      busy_nxt      = busy;
      sample_nxt    = 1'b0;
      done_nxt      = 1'b0;
      pass_nxt      = pass;
      init_fail_nxt = init_fail;
      fail_mask_nxt = fail_mask;
      tmr_clr       = 1'b0;
      tmr_en        = 1'b0;

      case (state)
         IDLE, FIN: begin
            abcd_nxt  = 4'b1111;
            busy_nxt  = 1'b0;
            tmr_clr   = 1'b1;
            state_nxt = IDLE;
            if (start) begin
               state_nxt     = INIT;
               busy_nxt      = 1'b1;
               step_nxt      = 3'd0;
               pass_nxt      = 1'b0;
               init_fail_nxt = 1'b0;
               fail_mask_nxt = 4'b0000;
            end
         end

         INIT: begin
            tmr_en = 1'b1;
            if (settle_hit) begin
               sample_nxt = 1'b1;
               state_nxt  = APPLY;
               if (q_in != 1'b1) begin
                  init_fail_nxt = 1'b1;
                  fail_mask_nxt = 4'b1111;
               end
            end
         end

         APPLY: begin
            abcd_nxt  = step_vec(step);
            tmr_clr   = 1'b1;
            state_nxt = SETTLE;
         end

         SETTLE: begin
            tmr_en = 1'b1;
            if (settle_hit) begin
               sample_nxt = 1'b1;
               state_nxt  = HOLD;
               if (q_in != step_exp(step)) begin
                  fail_mask_nxt[step_pin(step)] = 1'b1;
               end
            end
         end

         HOLD: begin
            tmr_en = 1'b1;
            // Apply the next vector straight from HOLD so each step spans
            // exactly DWELL edges; a short DWELL exits on the first HOLD edge.
            if (dwell_hit) begin
               if (step == 3'(NUM_STEPS - 1)) begin
                  state_nxt = FIN;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  pass_nxt  = ~init_fail & (fail_mask == 4'b0000);
               end else begin
                  step_nxt  = step + 3'd1;
                  abcd_nxt  = step_vec(step + 3'd1);
                  tmr_clr   = 1'b1;
                  state_nxt = SETTLE;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            abcd_nxt  = 4'b1111;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         step      <= 3'd0;
         abcd      <= 4'b1111;
         busy      <= 1'b0;
         sample    <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         init_fail <= 1'b0;
         fail_mask <= 4'b0000;
      end else begin
         state     <= state_nxt;
         step      <= step_nxt;
         abcd      <= abcd_nxt;
         busy      <= busy_nxt;
         sample    <= sample_nxt;
         done      <= done_nxt;
         pass      <= pass_nxt;
         init_fail <= init_fail_nxt;
         fail_mask <= fail_mask_nxt;
      end
   end

endmodule
